// File: rtl/usrt_tx_sched.sv
// Transmit scheduler for the USRT link: round-robin grant between two byte
// requesters, then shifts the granted byte out on txd as start bit, eight
// data bits LSB first, optional parity bit and stop bit. Every bit step is
// gated by the qualified baud tick (en_usrt & RTS).
module usrt_tx_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_usrt,
  input  logic       RTS,
  input  logic       par_en,
  input  logic       par_odd,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] data_reg, data_next;
  logic       par_en_reg, par_en_next;
  logic       par_odd_reg, par_odd_next;
  logic [2:0] idx_reg, idx_next;
  logic       ptr_reg, ptr_next;      // last requester granted (0 or 1)
  logic       txd_reg, txd_next;
  logic       gnt0_reg, gnt0_next;
  logic       gnt1_reg, gnt1_next;
  logic       done_reg, done_next;
  logic       busy_reg, busy_next;
  logic       pick1;
  logic       qt;

  // A baud tick only counts while the far end allows sending.
  assign qt = en_usrt & RTS;

  assign gnt0 = gnt0_reg;
  assign gnt1 = gnt1_reg;
  assign txd  = txd_reg;
  assign busy = busy_reg;
  assign done = done_reg;

  // Next-state, arbitration and serial bit selection.
  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    par_en_next  = par_en_reg;
    par_odd_next = par_odd_reg;
    idx_next     = idx_reg;
    ptr_next     = ptr_reg;
    txd_next     = txd_reg;
    gnt0_next    = 1'b0;
    gnt1_next    = 1'b0;
    done_next    = 1'b0;
    pick1        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        txd_next = 1'b1;
        if (req0 | req1) begin
          // On a tie the requester not served last wins.
          pick1        = req1 & (~req0 | ~ptr_reg);
          gnt0_next    = ~pick1;
          gnt1_next    = pick1;
          ptr_next     = pick1;
          data_next    = pick1 ? data1 : data0;
          par_en_next  = par_en;
          par_odd_next = par_odd;
          state_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (qt) begin
          state_next = S_START;
          txd_next   = 1'b0;
        end
      end
      S_START: begin
        if (qt) begin
          state_next = S_DATA;
          idx_next   = 3'd0;
          txd_next   = data_reg[0];
        end
      end
      S_DATA: begin
        if (qt) begin
          if (idx_reg == 3'd7) begin
            if (par_en_reg) begin
              state_next = S_PAR;
              txd_next   = par_odd_reg ? ~^data_reg : ^data_reg;
            end else begin
              state_next = S_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            idx_next = idx_reg + 3'd1;
            txd_next = data_reg[idx_reg + 3'd1];
          end
        end
      end
      S_PAR: begin
        if (qt) begin
          state_next = S_STOP;
          txd_next   = 1'b1;
        end
      end
      S_STOP: begin
        if (qt) begin
          state_next = S_IDLE;
          txd_next   = 1'b1;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      data_reg    <= 8'h00;
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      idx_reg     <= 3'd0;
      ptr_reg     <= 1'b1;
      txd_reg     <= 1'b1;
      gnt0_reg    <= 1'b0;
      gnt1_reg    <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      par_en_reg  <= par_en_next;
      par_odd_reg <= par_odd_next;
      idx_reg     <= idx_next;
      ptr_reg     <= ptr_next;
      txd_reg     <= txd_next;
      gnt0_reg    <= gnt0_next;
      gnt1_reg    <= gnt1_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

endmodule

// File: tb/tb_usrt_tx_sched.sv
// Bench for usrt_tx_sched: stimulus pushes the expected serial frame of each
// request into a queue; a monitor pops a frame on every grant and follows
// the line bit by bit on each qualified tick.
module tb_usrt_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_usrt = 1'b0;
  logic       RTS = 1'b0;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       gnt0, gnt1, txd, busy, done;

  usrt_tx_sched dut (
    .clk(clk), .rst(rst), .en_usrt(en_usrt), .RTS(RTS),
    .par_en(par_en), .par_odd(par_odd),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          len;
    logic [10:0] bits;
  } frame_t;

  frame_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int model_last = 1;
  int last_periods = 0;
  int last_stalls = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pk(input logic g0, input logic g1, input logic t,
                            input logic b, input logic d);
    return int'({g0, g1, t, b, d});
  endfunction

  // Line image of one frame: start, data LSB first, optional parity, stop.
  function automatic frame_t make_frame(input int id, input logic [7:0] d,
                                        input bit pen, input bit podd);
    frame_t f;
    int ones;
    ones   = 0;
    f.id   = id;
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f.bits[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (pen) begin
      f.bits[9]  = podd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      f.bits[10] = 1'b1;
      f.len      = 11;
    end else begin
      f.bits[9] = 1'b1;
      f.len     = 10;
    end
    return f;
  endfunction

  // Monitor: one check per cycle, sampled on the falling edge.
  initial begin : monitor
    bit     active;
    bit     qt_l;
    int     pos;
    logic   ebit;
    frame_t cur;
    active = 1'b0;
    qt_l   = 1'b0;
    pos    = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0;
        exp_q.delete();
        chk("reset_outputs", pk(gnt0, gnt1, txd, busy, done),
            pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      end else if (active) begin
        if (qt_l) pos++;
        if (pos == cur.len) begin
          chk("frame_done", pk(gnt0, gnt1, txd, busy, done),
              pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
          active = 1'b0;
        end else begin
          ebit = (pos < 0) ? 1'b1 : cur.bits[pos];
          if (qt_l)
            chk("bit_new", pk(gnt0, gnt1, txd, busy, done),
                pk(1'b0, 1'b0, ebit, 1'b1, 1'b0));
          else
            chk("bit_hold", pk(gnt0, gnt1, txd, busy, done),
                pk(1'b0, 1'b0, ebit, 1'b1, 1'b0));
        end
      end else if (gnt0 | gnt1) begin
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant", pk(gnt0, gnt1, txd, busy, done),
              pk(cur.id == 0, cur.id == 1, 1'b1, 1'b1, 1'b0));
          active = 1'b1;
          pos    = -1;
        end
      end else begin
        chk("idle", pk(gnt0, gnt1, txd, busy, done),
            pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      qt_l = en_usrt & RTS;
    end
  end

  // Waits for the grant of requester id; from IDLE it must come one edge later.
  task automatic wait_gnt(input int id);
    int cnt;
    bit got;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 50) begin
      en_usrt = 1'($urandom_range(0, 1));
      RTS     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cnt++;
      if ((id == 0 && gnt0) || (id == 1 && gnt1)) got = 1'b1;
    end
    chk("gnt_latency", cnt, 1);
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // Drives baud ticks until done; mode 0 = tick every other cycle with RTS
  // low on tick numbers st_lo..st_hi, mode 1 = random ticks and RTS.
  task automatic run_frame(input int mode, input int st_lo, input int st_hi,
                           input bit wiggle, input int other);
    int pulses, periods, stalls, cyc;
    bit started, e, r, fin;
    pulses = 0; periods = 0; stalls = 0; cyc = 0;
    started = 1'b0; fin = 1'b0;
    while (!fin) begin
      if (mode == 0) e = ((cyc % 2) == 0);
      else e = ($urandom_range(0, 99) < 50);
      r = 1'b1;
      if (e) begin
        pulses++;
        if (mode == 0) r = !(pulses >= st_lo && pulses <= st_hi);
        else r = ($urandom_range(0, 99) < 80);
        if (started) begin
          periods++;
          if (!r) stalls++;
        end else if (r) begin
          started = 1'b1;
        end
      end
      en_usrt = e;
      RTS     = r;
      if (wiggle) begin
        par_en  = 1'($urandom_range(0, 1));
        par_odd = 1'($urandom_range(0, 1));
        data0   = 8'($urandom);
        data1   = 8'($urandom);
        if (other == 0) req0 = (cyc < 2);
        else req1 = (cyc < 2);
      end
      @(posedge clk); #1;
      cyc++;
      if (done) fin = 1'b1;
      else if (cyc > 3000) begin
        chk("frame_timeout", 0, 1);
        fin = 1'b1;
      end
    end
    en_usrt = 1'b0;
    RTS     = 1'b1;
    if (wiggle) begin
      if (other == 0) req0 = 1'b0;
      else req1 = 1'b0;
    end
    last_periods = periods;
    last_stalls  = stalls;
  endtask

  // pattern: 1 = req0, 2 = req1, 3 = both.
  task automatic issue(input int pattern, input logic [7:0] d0,
                       input logic [7:0] d1, input bit pen, input bit podd,
                       input int mode, input int st_lo, input int st_hi);
    int order[2];
    int n;
    data0   = d0;
    data1   = d1;
    par_en  = pen;
    par_odd = podd;
    if (pattern == 3) begin
      n = 2;
      order[0] = (model_last == 1) ? 0 : 1;
      order[1] = 1 - order[0];
    end else begin
      n = 1;
      order[0] = pattern - 1;
      order[1] = 0;
    end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(make_frame(order[k], (order[k] == 0) ? d0 : d1, pen, podd));
      model_last = order[k];
    end
    if ((pattern & 1) != 0) req0 = 1'b1;
    if ((pattern & 2) != 0) req1 = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_gnt(order[k]);
      run_frame(mode, st_lo, st_hi, n == 1, 1 - order[k]);
      chk("frame_periods", last_periods - last_stalls, pen ? 11 : 10);
    end
  endtask

  // Stimulus sequence.
  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    RTS = 1'b1;

    // Tie right after reset: req0 first, then 0x3C from req1; tie again -> req0.
    issue(3, 8'hA5, 8'h3C, 1'b0, 1'b0, 0, 0, 0);
    issue(3, 8'h81, 8'h7E, 1'b0, 1'b0, 0, 0, 0);
    // Plain, even parity and odd parity frames of 0xA5.
    issue(1, 8'hA5, 8'h00, 1'b0, 1'b0, 0, 0, 0);
    issue(1, 8'hA5, 8'h00, 1'b1, 1'b0, 0, 0, 0);
    issue(1, 8'hA5, 8'h00, 1'b1, 1'b1, 0, 0, 0);
    // Three stalled ticks while data[3] is on the line.
    issue(1, 8'hA5, 8'h00, 1'b0, 1'b0, 0, 6, 8);
    chk("stall_periods", last_periods, 13);
    // Ticks with RTS low while waiting for the start bit.
    issue(2, 8'h00, 8'h3C, 1'b0, 1'b0, 0, 1, 3);
    chk("wait_stall_periods", last_periods, 10);

    for (int i = 0; i < 30; i++) begin
      int lo;
      lo = $urandom_range(1, 12);
      issue($urandom_range(1, 3), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 1), lo, lo + $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of the data bits.
    exp_q.push_back(make_frame(0, 8'hA5, 1'b0, 1'b0));
    model_last = 0;
    data0  = 8'hA5;
    par_en = 1'b0;
    req0   = 1'b1;
    wait_gnt(0);
    repeat (5) begin
      en_usrt = 1'b1; RTS = 1'b1;
      @(posedge clk); #1;
      en_usrt = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rst_txd", int'(txd), 1);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    model_last = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    issue(2, 8'h00, 8'hC3, 1'b1, 1'b1, 1, 0, 0);
    issue(3, 8'h5A, 8'h0F, 1'b1, 1'b0, 1, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usrt_tx_sched.md
# usrt_tx_sched

Transmit-side scheduler for the USRT link. Arbitrates round-robin between two frame requesters and sequences each granted byte onto `txd` as start bit, 8 data bits (LSB first), optional parity and stop bit. Bit sequencing follows the same baud-tick discipline as the bit counter: advance only on `en_usrt & RTS`. Sits between the measurement/host byte sources and the serial pin.

## Interface
- No parameters; data width fixed at 8.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en_usrt`  in  1  baud tick, one-`clk` pulse per bit period.
- `RTS`  in  1  flow control; 1 = sequencing allowed, 0 = freeze current bit.
- `par_en`  in  1  1 = insert parity bit; sampled at grant.
- `par_odd`  in  1  1 = odd parity, 0 = even; sampled at grant.
- `req0`, `req1`  in  1  frame request; held high until matching grant.
- `data0`, `data1`  in  8  byte for requester; sampled at grant edge.
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse; data captured.
- `txd`  out  1  serial line, registered, idle high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the stop bit period ends.

## Operation
- States: IDLE, WAIT, START, DATA, PAR, STOP.
- IDLE: `txd`=1. On an edge with any `req` high, grant one requester:
  - only one high -> that one;
  - both high -> the one not granted last. The last-grant pointer resets to 1, so `req0` wins the first tie.
  - The grant captures data, `par_en` and `par_odd`, sets `gntN`=1 for the next cycle only, updates the pointer and moves to WAIT.
- Qualified tick `qt` = `en_usrt & RTS`. Every state below advances only on `qt`. With `RTS`=0, ticks are ignored and `txd` holds.
- WAIT: `txd`=1; `qt` -> START, `txd`<=0.
- START: `qt` -> DATA, bit index 0, `txd`<=data[0].
- DATA: `qt` increments the 3-bit index and drives `txd`<=data[idx+1]. After bit 7, `qt` goes to PAR if the captured `par_en`=1, else to STOP.
- PAR: `txd`=^data for even parity, ~^data for odd parity. `qt` -> STOP.
- STOP: `txd`=1. `qt` -> IDLE with `done`=1 for that one cycle.
- Frame length: 10 bit periods (11 with parity), counted from the first `qt`.
- `req` changes while not in IDLE are ignored; new grants happen only from IDLE.
- Changing `par_en`/`par_odd` mid-frame has no effect.
- Reset (async, any state) forces:
  - state IDLE, `txd`=1;
  - `gnt0`=`gnt1`=`busy`=`done`=0;
  - pointer=1, captured data=0.
  - Any frame in progress is abandoned; no `done` is issued.

## Timing
- All outputs are registered; none has a combinational path from inputs.
- Grant latency: `req` high at edge N -> `gnt` high during cycle N+1 -> `busy` high from N+1.
- `txd` changes on the same edge that samples `qt`, so bit boundaries align to `en_usrt` pulses.
- `done` rises on the edge sampling the final `qt`. `busy` falls on that same edge.
- Back-to-back: a `req` held through `done` is granted on the next edge, at the earliest 1 cycle after `done`.
- `qt` arriving in the same cycle as a grant is not counted; WAIT needs a later `qt`.
- Stall: each `RTS`=0 tick lengthens the current bit by one period. No bits are skipped or duplicated.

## Test plan
- Reset, `req0`=1, `data0`=0xA5, `par_en`=0, `RTS`=1:
  - `gnt0` pulses one cycle.
  - `txd` per tick: 0,1,0,1,0,0,1,0,1,1.
  - `done` pulses after the 10th tick; `busy` then falls.
- Same frame with `par_en`=1, `par_odd`=0 -> parity bit 0, 11 periods. With `par_odd`=1 -> parity bit 1.
- `req0`=`req1`=1 right after reset:
  - `gnt0` first, its frame completes, then `gnt1` (`data1`=0x3C sent as 0,0,0,1,1,1,1,0,0,1).
  - A second tie then grants `req0` again.
- `RTS`=0 for 3 ticks while `data[3]` is on the line -> `txd` holds `data[3]` for 4 periods; total frame is 13 periods; `done` pulses once.
- `en_usrt` pulses in WAIT with `RTS`=0 -> `txd` stays 1 and state stays WAIT; first tick with `RTS`=1 produces the start bit.
- `rst`=0 asserted asynchronously mid-DATA -> `txd`=1 and `busy`=0 immediately, no `done`. After release, `req1` alone is granted normally.
